// File: rtl/pair_hmm_fx_pkg.sv
// Shared types and saturating fixed-point helpers for the Pair-HMM PE.
// Contents:
//   FX_W / FX_FRAC        default datapath width and fraction bits (1.0 = 1 << FX_FRAC)
//   fx_probs_t            transition probabilities a_mm, a_im (= a_dm), a_mi, a_ii (= a_dd), a_md
//   fx_vals_in_t          m, i, d delivered by the upstream PE
//   fx_vals_out_t         m, i, d, t_a, t_b produced by this PE
//   fx_lane_state_t       per-lane recurrence state m_p, i_p, ta_p, tb_p
//   fx_add_sat            min(a + b, 2^W - 1)
//   fx_mul_sat            min((a * b) >> frac, 2^W - 1), truncating
package pair_hmm_fx_pkg;

   localparam int          FX_W    = 16;
   localparam int unsigned FX_FRAC = 14;
   localparam logic [FX_W-1:0] FX_MAX = {FX_W{1'b1}};

   typedef struct packed {
      logic [FX_W-1:0] a_mm;
      logic [FX_W-1:0] a_im;
      logic [FX_W-1:0] a_mi;
      logic [FX_W-1:0] a_ii;
      logic [FX_W-1:0] a_md;
   } fx_probs_t;

   typedef struct packed {
      logic [FX_W-1:0] m;
      logic [FX_W-1:0] i;
      logic [FX_W-1:0] d;
   } fx_vals_in_t;

   typedef struct packed {
      logic [FX_W-1:0] m;
      logic [FX_W-1:0] i;
      logic [FX_W-1:0] d;
      logic [FX_W-1:0] t_a;
      logic [FX_W-1:0] t_b;
   } fx_vals_out_t;

   typedef struct packed {
      logic [FX_W-1:0] m_p;
      logic [FX_W-1:0] i_p;
      logic [FX_W-1:0] ta_p;
      logic [FX_W-1:0] tb_p;
   } fx_lane_state_t;

   function automatic logic [FX_W-1:0] fx_add_sat(input logic [FX_W-1:0] a,
                                                  input logic [FX_W-1:0] b);
      logic [FX_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[FX_W]) begin
         return FX_MAX;
      end else begin
         return sum[FX_W-1:0];
      end
   endfunction

   function automatic logic [FX_W-1:0] fx_mul_sat(input logic [FX_W-1:0] a,
                                                  input logic [FX_W-1:0] b,
                                                  input int unsigned     frac);
      logic [2*FX_W-1:0] prod;
      prod = {{FX_W{1'b0}}, a} * {{FX_W{1'b0}}, b};
      prod = prod >> frac;
      if (|prod[2*FX_W-1:FX_W]) begin
         return FX_MAX;
      end else begin
         return prod[FX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/pair_hmm_pe_fx_mlane_lane_state.sv
// Per-lane recurrence state register file for the multi-lane PE.
// Ports:
//   clock, reset        clock and synchronous active-high clear of every entry
//   rd_idx / rd_data    asynchronous read of one lane's {m_p, i_p, ta_p, tb_p}
//   wr_en/wr_idx/wr_data synchronous write of one lane's new state
module pe_lane_state
   import pair_hmm_fx_pkg::*;
#(
   parameter int LANES = 4,
   parameter int LW    = 2
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [LW-1:0]  rd_idx,
   output fx_lane_state_t rd_data,
   input  logic           wr_en,
   input  logic [LW-1:0]  wr_idx,
   input  fx_lane_state_t wr_data
);

   fx_lane_state_t mem_r [LANES];

   // Storage: all entries cleared on reset, one lane written per cycle otherwise
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < LANES; k++) begin
            mem_r[k] <= '0;
         end
      end else if (wr_en) begin
         mem_r[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/pair_hmm_pe_fx_mlane.sv
// Fixed-point multi-lane Pair-HMM processing element: one M/I/D cell update per accepted op.
// LANES independent alignments interleave through a 3-stage pipeline; a per-lane busy bit keeps
// a lane's next op out until its previous result has been written back.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   in_valid / in_ready     op handshake; in_lane selects the context, in_first zeroes its state
//   in_probs, in_prior      transition probabilities and emission prior
//   in_vals                 m, i, d from the upstream PE
//   out_valid / out_ready   result handshake; out_lane, out_vals held while stalled
module pair_hmm_pe_fx_mlane
   import pair_hmm_fx_pkg::*;
#(
   parameter  int          W     = FX_W,
   parameter  int unsigned FRAC  = FX_FRAC,
   parameter  int          LANES = 4,
   localparam int          LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LW-1:0]   in_lane,
   input  logic            in_first,
   input  fx_probs_t       in_probs,
   input  logic [W-1:0]    in_prior,
   input  fx_vals_in_t     in_vals,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LW-1:0]   out_lane,
   output fx_vals_out_t    out_vals
);

   localparam int NSLOT = 1 << LW;

   logic            lane_ok_s, in_ready_s, accept_s, stall_s, advance_s, lane_wr_s;
   logic [NSLOT-1:0] busy_r, busy_next_s;
   fx_lane_state_t  rd_state_s, prev_s, wr_state_s;
   logic [W-1:0]    fin_i_s, fin_d_s;

   // Stage 1: state-dependent sums plus the operands the multipliers need
   logic            s1_valid_r;
   logic [LW-1:0]   s1_lane_r;
   logic [W-1:0]    s1_sum_t_r, s1_prior_r, s1_a_mi_r, s1_m_p_r, s1_a_ii_r, s1_i_p_r;
   logic [W-1:0]    s1_a_md_r, s1_in_m_r, s1_in_d_r, s1_a_dm_r, s1_sum_id_r, s1_a_mm_r;

   // Stage 2: saturated products
   logic            s2_valid_r;
   logic [LW-1:0]   s2_lane_r;
   logic [W-1:0]    s2_m_r, s2_p_mi_r, s2_p_ii_r, s2_p_md_r, s2_p_dd_r, s2_t_a_r, s2_t_b_r;

   // Stage 3: output register
   logic            out_valid_r;
   logic [LW-1:0]   out_lane_r;
   fx_vals_out_t    out_vals_r;

   // A lane index is only legal below LANES; with a power-of-two count every index is legal
   generate
      if (NSLOT == LANES) begin : g_lane_pow2
         assign lane_ok_s = 1'b1;
      end else begin : g_lane_range
         assign lane_ok_s = ({1'b0, in_lane} < (LW+1)'(LANES));
      end
   endgenerate

   // The whole pipe freezes while the output holds an unconsumed result
   assign stall_s    = out_valid_r && !out_ready;
   assign advance_s  = !stall_s;
   assign in_ready_s = !reset && !stall_s && lane_ok_s && !busy_r[in_lane];
   assign accept_s   = in_valid && in_ready_s;
   assign lane_wr_s  = advance_s && s2_valid_r;

   pe_lane_state #(
      .LANES (LANES),
      .LW    (LW)
   ) u_lane_state (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (in_lane),
      .rd_data (rd_state_s),
      .wr_en   (lane_wr_s),
      .wr_idx  (s2_lane_r),
      .wr_data (wr_state_s)
   );

   // First op of a row sees an all-zero lane state
   always_comb begin
      prev_s = '0;
      if (in_first) begin
         prev_s = '0;
      end else begin
         prev_s = rd_state_s;
      end
   end

   // Final adds feeding the output register and the lane write-back
   always_comb begin
      fin_i_s    = fx_add_sat(s2_p_mi_r, s2_p_ii_r);
      fin_d_s    = fx_add_sat(s2_p_md_r, s2_p_dd_r);
      wr_state_s = '{m_p: s2_m_r, i_p: fin_i_s, ta_p: s2_t_a_r, tb_p: s2_t_b_r};
   end

   // Busy scoreboard: set on accept, cleared when the lane's result loads the output
   always_comb begin
      busy_next_s = busy_r;
      for (int k = 0; k < NSLOT; k++) begin
         busy_next_s[k] = (busy_r[k] && !(lane_wr_s && (s2_lane_r == LW'(k))))
                          || (accept_s && (in_lane == LW'(k)));
      end
   end

   // Busy register
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_r <= {NSLOT{1'b0}};
      end else begin
         busy_r <= busy_next_s;
      end
   end

   // Stage 1 register: sums and operands captured on the accept edge
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_r  <= 1'b0;
         s1_lane_r   <= {LW{1'b0}};
         s1_sum_t_r  <= {W{1'b0}};
         s1_prior_r  <= {W{1'b0}};
         s1_a_mi_r   <= {W{1'b0}};
         s1_m_p_r    <= {W{1'b0}};
         s1_a_ii_r   <= {W{1'b0}};
         s1_i_p_r    <= {W{1'b0}};
         s1_a_md_r   <= {W{1'b0}};
         s1_in_m_r   <= {W{1'b0}};
         s1_in_d_r   <= {W{1'b0}};
         s1_a_dm_r   <= {W{1'b0}};
         s1_sum_id_r <= {W{1'b0}};
         s1_a_mm_r   <= {W{1'b0}};
      end else if (advance_s) begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_lane_r   <= in_lane;
            s1_sum_t_r  <= fx_add_sat(prev_s.ta_p, prev_s.tb_p);
            s1_prior_r  <= in_prior;
            s1_a_mi_r   <= in_probs.a_mi;
            s1_m_p_r    <= prev_s.m_p;
            s1_a_ii_r   <= in_probs.a_ii;
            s1_i_p_r    <= prev_s.i_p;
            s1_a_md_r   <= in_probs.a_md;
            s1_in_m_r   <= in_vals.m;
            s1_in_d_r   <= in_vals.d;
            s1_a_dm_r   <= in_probs.a_im;
            s1_sum_id_r <= fx_add_sat(in_vals.i, in_vals.d);
            s1_a_mm_r   <= in_probs.a_mm;
         end
      end
   end

   // Stage 2 register: products; a_ii doubles as a_dd for the delete path
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         s2_lane_r  <= {LW{1'b0}};
         s2_m_r     <= {W{1'b0}};
         s2_p_mi_r  <= {W{1'b0}};
         s2_p_ii_r  <= {W{1'b0}};
         s2_p_md_r  <= {W{1'b0}};
         s2_p_dd_r  <= {W{1'b0}};
         s2_t_a_r   <= {W{1'b0}};
         s2_t_b_r   <= {W{1'b0}};
      end else if (advance_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_lane_r <= s1_lane_r;
            s2_m_r    <= fx_mul_sat(s1_prior_r, s1_sum_t_r, FRAC);
            s2_p_mi_r <= fx_mul_sat(s1_a_mi_r, s1_m_p_r, FRAC);
            s2_p_ii_r <= fx_mul_sat(s1_a_ii_r, s1_i_p_r, FRAC);
            s2_p_md_r <= fx_mul_sat(s1_a_md_r, s1_in_m_r, FRAC);
            s2_p_dd_r <= fx_mul_sat(s1_a_ii_r, s1_in_d_r, FRAC);
            s2_t_a_r  <= fx_mul_sat(s1_a_dm_r, s1_sum_id_r, FRAC);
            s2_t_b_r  <= fx_mul_sat(s1_a_mm_r, s1_in_m_r, FRAC);
         end
      end
   end

   // Output register: data only reloads for a real result so bubbles leave it untouched
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_lane_r  <= {LW{1'b0}};
         out_vals_r  <= '0;
      end else if (advance_s) begin
         out_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            out_lane_r <= s2_lane_r;
            out_vals_r <= '{m: s2_m_r, i: fin_i_s, d: fin_d_s, t_a: s2_t_a_r, t_b: s2_t_b_r};
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_lane  = out_lane_r;
   assign out_vals  = out_vals_r;

endmodule

// File: tb/tb_pair_hmm_pe_fx_mlane.sv
module tb_pair_hmm_pe_fx_mlane;
   import pair_hmm_fx_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_lane;
   logic         in_first;
   fx_probs_t    in_probs;
   logic [15:0]  in_prior;
   fx_vals_in_t  in_vals;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_lane;
   fx_vals_out_t out_vals;

   always #5 clock = ~clock;

   pair_hmm_pe_fx_mlane #(.W(16), .FRAC(14), .LANES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lane   (in_lane),
      .in_first  (in_first),
      .in_probs  (in_probs),
      .in_prior  (in_prior),
      .in_vals   (in_vals),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lane  (out_lane),
      .out_vals  (out_vals)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic int add_sat(input int a, input int b);
      return (a + b > 65535) ? 65535 : a + b;
   endfunction

   function automatic int mul_sat(input int a, input int b);
      longint p;
      p = (longint'(a) * longint'(b)) >> 14;
      return (p > 65535) ? 65535 : int'(p);
   endfunction

   typedef struct {
      int lane; int m; int i; int d; int ta; int tb;
      int left;   // advancing edges still needed before reaching the output
   } item_t;

   item_t pend[$];
   item_t oslot;
   bit    mv   = 1'b0;
   bit    live = 1'b0;
   int    sm[4], si[4], sta[4], stb[4];

   function automatic bit lane_busy(input int l);
      foreach (pend[k]) if (pend[k].lane == l) return 1'b1;
      return 1'b0;
   endfunction

   // Compare DUT against the model every cycle, then advance the model to the next edge
   always @(negedge clock) begin
      bit    stall, exp_rdy;
      item_t it;
      int    l, pm, pi, pta, ptb;
      stall   = mv && !out_ready;
      exp_rdy = !reset && !stall && !lane_busy(int'(in_lane));
      if (live) begin
         chk("out_valid", 32'(out_valid), 32'(mv));
         if (mv) begin
            chk("out_lane", 32'(out_lane), 32'(oslot.lane));
            chk("out_m", 32'(out_vals.m), 32'(oslot.m));
            chk("out_i", 32'(out_vals.i), 32'(oslot.i));
            chk("out_d", 32'(out_vals.d), 32'(oslot.d));
            chk("out_ta", 32'(out_vals.t_a), 32'(oslot.ta));
            chk("out_tb", 32'(out_vals.t_b), 32'(oslot.tb));
         end
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      end
      if (reset) begin
         pend.delete();
         mv   = 1'b0;
         live = 1'b1;
         for (int k = 0; k < 4; k++) begin
            sm[k] = 0; si[k] = 0; sta[k] = 0; stb[k] = 0;
         end
      end else if (live && !stall) begin
         if (pend.size() > 0 && pend[0].left == 1) begin
            oslot = pend.pop_front();
            mv    = 1'b1;
         end else begin
            mv = 1'b0;
         end
         foreach (pend[k]) pend[k].left--;
         if (in_valid && exp_rdy) begin
            l   = int'(in_lane);
            pm  = in_first ? 0 : sm[l];
            pi  = in_first ? 0 : si[l];
            pta = in_first ? 0 : sta[l];
            ptb = in_first ? 0 : stb[l];
            it.lane = l;
            it.m  = mul_sat(int'(in_prior), add_sat(pta, ptb));
            it.i  = add_sat(mul_sat(int'(in_probs.a_mi), pm), mul_sat(int'(in_probs.a_ii), pi));
            it.d  = add_sat(mul_sat(int'(in_probs.a_md), int'(in_vals.m)),
                            mul_sat(int'(in_probs.a_ii), int'(in_vals.d)));
            it.ta = mul_sat(int'(in_probs.a_im), add_sat(int'(in_vals.i), int'(in_vals.d)));
            it.tb = mul_sat(int'(in_probs.a_mm), int'(in_vals.m));
            it.left = 2;
            sm[l] = it.m; si[l] = it.i; sta[l] = it.ta; stb[l] = it.tb;
            pend.push_back(it);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] rnd16(input bit wide);
      return wide ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(16'h1000, 16'h4000));
   endfunction

   task automatic set_uniform(input int lane, input bit first, input logic [15:0] p,
                              input logic [15:0] v, input logic [15:0] prior);
      in_valid = 1'b1;
      in_lane  = 2'(lane);
      in_first = first;
      in_probs = '{a_mm: p, a_im: p, a_mi: p, a_ii: p, a_md: p};
      in_vals  = '{m: v, i: v, d: v};
      in_prior = prior;
   endtask

   task automatic set_random(input int lane, input bit first, input bit wide);
      in_valid = 1'b1;
      in_lane  = 2'(lane);
      in_first = first;
      in_probs = '{a_mm: rnd16(wide), a_im: rnd16(wide), a_mi: rnd16(wide),
                   a_ii: rnd16(wide), a_md: rnd16(wide)};
      in_vals  = '{m: rnd16(wide), i: rnd16(wide), d: rnd16(wide)};
      in_prior = rnd16(wide);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_lane   = 2'd0;
      in_first  = 1'b0;
      in_probs  = '0;
      in_prior  = 16'h0000;
      in_vals   = '0;
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_lane", 32'(out_lane), 32'd0);
      chk("rst_out_vals_nz", 32'(|out_vals), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;

      // Tests 1 and 2: lane 0 first op, then two dependent ops retried every cycle
      for (int k = 0; k < 10; k++) begin
         if (k == 0) set_uniform(0, 1'b1, 16'h2000, 16'h2000, 16'h4000);
         if (k == 1) in_first = 1'b0;
         if (k == 7) in_valid = 1'b0;
         #1;
         case (k)
            0: chk("t1_ready", 32'(in_ready), 32'd1);
            1, 2, 4, 5: chk("t2_blocked", 32'(in_ready), 32'd0);
            3: begin
               chk("t1_valid", 32'(out_valid), 32'd1);
               chk("t1_m", 32'(out_vals.m), 32'h0000);
               chk("t1_i", 32'(out_vals.i), 32'h0000);
               chk("t1_d", 32'(out_vals.d), 32'h2000);
               chk("t1_ta", 32'(out_vals.t_a), 32'h2000);
               chk("t1_tb", 32'(out_vals.t_b), 32'h1000);
               chk("t2_reaccept", 32'(in_ready), 32'd1);
            end
            6: begin
               chk("t2_m", 32'(out_vals.m), 32'h3000);
               chk("t2_i", 32'(out_vals.i), 32'h0000);
            end
            9: begin
               chk("t2_third_valid", 32'(out_valid), 32'd1);
               chk("t2_third_i", 32'(out_vals.i), 32'h1800);
            end
            default: begin end
         endcase
         cyc();
      end

      // Test 3: four lanes back to back
      for (int k = 0; k < 8; k++) begin
         if (k < 4) set_random(k, 1'b1, 1'b0);
         else in_valid = 1'b0;
         #1;
         if (k < 4) chk("t3_ready", 32'(in_ready), 32'd1);
         if (k >= 3 && k <= 6) begin
            chk("t3_valid", 32'(out_valid), 32'd1);
            chk("t3_lane", 32'(out_lane), 32'(k - 3));
         end
         cyc();
      end

      // Test 4: five-cycle output stall with the pipe full
      for (int k = 0; k < 13; k++) begin
         if (k < 4) set_random(k, 1'b1, 1'b0);
         else begin
            in_valid = 1'b0;
            in_lane  = 2'd0;
         end
         out_ready = !(k >= 4 && k <= 8);
         #1;
         if (k < 4) chk("t4_ready", 32'(in_ready), 32'd1);
         if (k == 3) chk("t4_lane0", 32'(out_lane), 32'd0);
         if (k >= 4 && k <= 8) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_lane", 32'(out_lane), 32'd1);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
         end
         if (k >= 9 && k <= 11) chk("t4_drain_lane", 32'(out_lane), 32'(k - 8));
         if (k == 12) chk("t4_empty", 32'(out_valid), 32'd0);
         cyc();
      end

      // Test 5: saturation of t_a/t_b, then of m from a saturated lane state
      for (int k = 0; k < 8; k++) begin
         if (k == 0) set_uniform(1, 1'b1, 16'h4000, 16'hFFFF, 16'h1000);
         if (k == 1) begin
            in_first = 1'b0;
            in_prior = 16'hFFFF;
         end
         if (k == 4) in_valid = 1'b0;
         #1;
         if (k == 3) begin
            chk("t5_ta_sat", 32'(out_vals.t_a), 32'hFFFF);
            chk("t5_tb_sat", 32'(out_vals.t_b), 32'hFFFF);
         end
         if (k == 6) chk("t5_m_sat", 32'(out_vals.m), 32'hFFFF);
         cyc();
      end

      // Test 6: reset with two ops in flight
      for (int k = 0; k < 8; k++) begin
         if (k == 0) set_random(0, 1'b1, 1'b0);
         if (k == 1) set_random(1, 1'b1, 1'b0);
         if (k == 2) begin
            in_valid = 1'b0;
            reset    = 1'b1;
         end
         if (k == 3) begin
            reset = 1'b0;
            set_uniform(0, 1'b0, 16'h2000, 16'h2000, 16'h4000);
         end
         if (k == 4) in_valid = 1'b0;
         #1;
         if (k == 3) begin
            chk("t6_flushed", 32'(out_valid), 32'd0);
            chk("t6_busy_clear", 32'(in_ready), 32'd1);
         end
         if (k == 4) chk("t6_no_partial", 32'(out_valid), 32'd0);
         if (k == 6) begin
            chk("t6_m", 32'(out_vals.m), 32'h0000);
            chk("t6_d", 32'(out_vals.d), 32'h2000);
            chk("t6_tb", 32'(out_vals.t_b), 32'h1000);
         end
         cyc();
      end

      // Randomized traffic with back-pressure and occasional reset
      for (int n = 0; n < 2000; n++) begin
         set_random(int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0));
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
